// File: rtl/serial_popcount_capture_pkg.sv
// Shared types and constants for the serial popcount capture stage and its
// 7-segment display decoder.
package serial_popcount_capture_pkg;

  localparam int unsigned SEG_WIDTH = 7;
  localparam int unsigned NIB_W     = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Active-high segment patterns for hex digits 0..F, bit0 = segment a.
  localparam logic [SEG_WIDTH-1:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to 7-segment decoder with optional common-anode
// inversion.
module seg7_hex_decoder
  import serial_popcount_capture_pkg::*;
#(
  parameter bit SEG_INVERT = 1'b0
) (
  input  logic [NIB_W-1:0]     nib_i,
  output logic [SEG_WIDTH-1:0] seg_o
);

  assign seg_o = SEG_TABLE[nib_i] ^ {SEG_WIDTH{SEG_INVERT}};

endmodule

// File: rtl/serial_popcount_capture.sv
// Strobe-clocked serial word capture; displays the popcount of the last word
// or the completed-word counter on a registered 7-segment digit.
module serial_popcount_capture
  import serial_popcount_capture_pkg::*;
#(
  parameter int unsigned WORD_BITS  = 8,
  parameter bit          SEG_INVERT = 1'b0
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int unsigned BCNT_W = 4;
  localparam logic [SEG_WIDTH-1:0] SEG_RST = SEG_TABLE[0] ^ {SEG_WIDTH{SEG_INVERT}};

  logic clk, rst, din, strobe, mode, abort;
  logic unused_reserved;

  assign clk             = io_in[0];
  assign rst             = io_in[1];
  assign din             = io_in[2];
  assign strobe          = io_in[3];
  assign mode            = io_in[4];
  assign abort           = io_in[5];
  assign unused_reserved = ^io_in[7:6];

  function automatic logic [NIB_W-1:0] popcount(input logic [WORD_BITS-1:0] w);
    logic [NIB_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < WORD_BITS; i++) begin
      c = c + NIB_W'(w[i]);
    end
    return c;
  endfunction

  state_e                 state_q, state_d;
  logic [WORD_BITS-1:0]   sr_q, sr_d;
  logic [WORD_BITS-1:0]   hold_q, hold_d;
  logic [BCNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [NIB_W-1:0]       frame_q, frame_d;
  logic                   tgl_q, tgl_d;
  logic                   strobe_q;
  logic [SEG_WIDTH-1:0]   seg_q, seg_d;

  logic                   cap_c;
  logic                   last_bit_c;
  logic [WORD_BITS-1:0]   sr_shift_c;
  logic [NIB_W-1:0]       nib_c;
  logic [SEG_WIDTH-1:0]   seg_c;

  assign cap_c      = strobe & ~strobe_q;
  assign last_bit_c = (bit_cnt_q == BCNT_W'(WORD_BITS - 1));
  assign sr_shift_c = {sr_q[WORD_BITS-2:0], din};

  // State register plus datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      hold_q    <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      tgl_q     <= 1'b0;
      strobe_q  <= 1'b0;
      seg_q     <= SEG_RST;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      hold_q    <= hold_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      tgl_q     <= tgl_d;
      strobe_q  <= strobe;
      seg_q     <= seg_d;
    end
  end

  // Next state: abort always wins over a coincident capture
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else if (cap_c) begin
      case (state_q)
        IDLE:    state_d = SHIFT;
        SHIFT:   state_d = last_bit_c ? IDLE : SHIFT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath updates driven by the current state
  always_comb begin
    sr_d      = sr_q;
    hold_d    = hold_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    tgl_d     = tgl_q;
    if (abort) begin
      sr_d      = '0;
      bit_cnt_d = '0;
    end else if (cap_c) begin
      sr_d = sr_shift_c;
      case (state_q)
        IDLE: bit_cnt_d = BCNT_W'(1);
        SHIFT: begin
          if (last_bit_c) begin
            hold_d    = sr_shift_c;
            frame_d   = frame_q + NIB_W'(1);
            tgl_d     = ~tgl_q;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          end
        end
        default: bit_cnt_d = '0;
      endcase
    end
  end

  assign nib_c = mode ? frame_q : popcount(hold_q);

  seg7_hex_decoder #(
    .SEG_INVERT (SEG_INVERT)
  ) u_seg7 (
    .nib_i (nib_c),
    .seg_o (seg_c)
  );

  assign seg_d  = seg_c;
  assign io_out = {tgl_q, seg_q};

endmodule

// File: tb/tb_serial_popcount_capture.sv
// Directed bench for serial_popcount_capture: table-driven words plus
// hand-written abort, long-strobe, wrap and mid-word reset sequences.
module tb_serial_popcount_capture;

  logic       clk = 1'b0;
  logic       rst, din, strobe, mode, abort;
  logic [1:0] rsvd;
  logic [7:0] io_in, io_out;

  int n_checks = 0;
  int n_fail   = 0;

  assign io_in = {rsvd, abort, mode, strobe, din, rst, clk};

  always #5 clk = ~clk;

  serial_popcount_capture #(
    .WORD_BITS  (8),
    .SEG_INVERT (1'b0)
  ) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  typedef struct {
    logic [7:0] word;
    logic       mode;
    logic [6:0] exp_seg;
    logic       exp_tgl;
  } vec_t;

  vec_t       vecs [2];
  logic [6:0] wrap_seg [16];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    din    = b;
    strobe = 1'b1;
    cyc(2);
    strobe = 1'b0;
    cyc(2);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  initial begin
    vecs[0] = '{word: 8'hB5, mode: 1'b0, exp_seg: 7'h6D, exp_tgl: 1'b1};
    vecs[1] = '{word: 8'hFF, mode: 1'b0, exp_seg: 7'h7F, exp_tgl: 1'b0};
    wrap_seg = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
                 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3F};

    rst = 1'b1; din = 1'b0; strobe = 1'b0; mode = 1'b0; abort = 1'b0; rsvd = 2'b10;
    cyc(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("reset_seg", {1'b0, io_out[6:0]}, 8'h3F);
      check("reset_tgl", {7'b0, io_out[7]}, 8'h00);
    end

    for (int i = 0; i < 2; i++) begin
      mode = vecs[i].mode;
      send_word(vecs[i].word);
      check("vec_seg", {1'b0, io_out[6:0]}, {1'b0, vecs[i].exp_seg});
      check("vec_tgl", {7'b0, io_out[7]}, {7'b0, vecs[i].exp_tgl});
    end

    // Mode change lands one clock later
    mode = 1'b1;
    #1 check("mode_before_edge", {1'b0, io_out[6:0]}, 8'h7F);
    cyc(1);
    check("mode_frame2", {1'b0, io_out[6:0]}, 8'h5B);
    mode = 1'b0;
    cyc(1);
    check("mode_back", {1'b0, io_out[6:0]}, 8'h7F);

    // Partial word, abort pulse, then abort coincident with a strobe edge
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    check("partial_seg", {1'b0, io_out[6:0]}, 8'h7F);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check("abort_seg", {1'b0, io_out[6:0]}, 8'h7F);
    din = 1'b1; strobe = 1'b1; abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    cyc(1);
    strobe = 1'b0;
    cyc(2);
    check("abort_cap_seg", {1'b0, io_out[6:0]}, 8'h7F);
    check("abort_cap_tgl", {7'b0, io_out[7]}, 8'h00);
    send_word(8'h00);
    check("after_abort_seg", {1'b0, io_out[6:0]}, 8'h3F);
    check("after_abort_tgl", {7'b0, io_out[7]}, 8'h01);
    mode = 1'b1;
    cyc(1);
    check("after_abort_frame", {1'b0, io_out[6:0]}, 8'h4F);
    mode = 1'b0;
    cyc(1);

    // Strobe held high for many cycles yields a single capture
    din = 1'b1; strobe = 1'b1;
    cyc(10);
    strobe = 1'b0;
    cyc(2);
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    check("long_strobe_seg", {1'b0, io_out[6:0]}, 8'h06);
    check("long_strobe_tgl", {7'b0, io_out[7]}, 8'h00);
    mode = 1'b1;
    cyc(1);
    check("long_strobe_frame", {1'b0, io_out[6:0]}, 8'h66);

    // Counter view across a full 4-bit wrap
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst2_seg", {1'b0, io_out[6:0]}, 8'h3F);
    for (int i = 0; i < 16; i++) begin
      send_word(8'(i * 17 + 3));
      check("wrap_seg", {1'b0, io_out[6:0]}, {1'b0, wrap_seg[i]});
      check("wrap_tgl", {7'b0, io_out[7]}, (i % 2 == 0) ? 8'h01 : 8'h00);
    end

    // Reset in the middle of a word
    send_word(8'h0F);
    check("pre_rst_out", io_out, 8'h86);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst = 1'b1;
    cyc(1);
    check("midword_rst_out", io_out, 8'h3F);
    rst  = 1'b0;
    mode = 1'b0;
    send_word(8'h03);
    check("post_rst_seg", {1'b0, io_out[6:0]}, 8'h5B);
    check("post_rst_tgl", {7'b0, io_out[7]}, 8'h01);
    mode = 1'b1;
    cyc(1);
    check("post_rst_frame", {1'b0, io_out[6:0]}, 8'h06);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_popcount_capture.md
Name: serial_popcount_capture

Overview:
- Sequential stage that feeds the 8-bit combinational popcount/7-segment display, with that display folded in as the output end.
- Assembles an 8-bit word from a serial pin clocked by a strobe, then latches the completed word.
- Computes the word's popcount (0–8) and drives a registered 7-segment digit.
- Keeps a 4-bit count of completed words, selectable for display in hex. Fits the standard 8-in/8-out user-module pinout.

Parameters:
- WORD_BITS, 8: bits per serial word; legal range 2..15 (popcount must fit 4 bits).
- SEG_INVERT, 0: 1 inverts all seven segment outputs (common-anode); 0 is active-high.

Ports:
- io_in[0]  input  1  clk; all state updates on its rising edge.
- io_in[1]  input  1  rst; synchronous, active-high.
- io_in[2]  input  1  din; serial data, MSB first.
- io_in[3]  input  1  strobe; a rising edge captures din.
- io_in[4]  input  1  mode; 0 = show popcount of last word, 1 = show word counter (hex).
- io_in[5]  input  1  abort; discards a partially received word.
- io_in[7:6]  input  2  reserved; ignored.
- io_out[6:0]  output  7  segments a..g (bit0 = a), registered.
- io_out[7]  output  1  word_tgl; toggles once per completed word, registered.

Behaviour:
- Reset (rst=1 at a clk edge) has priority over everything and clears:
  - shift register, bit_cnt, hold word, frame_cnt, strobe_q and word_tgl to 0;
  - the FSM to IDLE;
  - io_out[6:0] to 0x3F (digit 0; inverted if SEG_INVERT), io_out[7] to 0.
- Edge detect: strobe_q <= strobe every cycle; cap = strobe & ~strobe_q. A strobe held high for any number of cycles yields exactly one capture.
- FSM has two states, IDLE (bit_cnt==0) and SHIFT.
  - IDLE, cap: sr <= {sr, din}; bit_cnt <= 1; go to SHIFT.
  - SHIFT, cap with bit_cnt < WORD_BITS-1: shift; bit_cnt++.
  - SHIFT, cap with bit_cnt == WORD_BITS-1, in the same edge:
    - hold <= {sr, din} (complete word);
    - frame_cnt <= frame_cnt+1, wrapping 15 -> 0;
    - word_tgl <= ~word_tgl;
    - bit_cnt <= 0; return to IDLE.
  - abort=1 in any state: sr and bit_cnt cleared, go to IDLE. abort beats a simultaneous cap, so that bit is discarded. hold, frame_cnt and the display are untouched.
- Display path:
  - pc = popcount(hold), 4 bits.
  - nib = mode ? frame_cnt : pc.
  - io_out[6:0] <= seg(nib) every cycle.
- Latency: if cap completes a word at edge N, the hold word and frame count update at N and io_out updates at N+1. A mode change is visible 1 cycle later.
- Segment codes, hex 0..F:
  - 0–7: 3F 06 5B 4F 66 6D 7D 07;
  - 8–F: 7F 6F 77 7C 39 5E 79 71.
- WORD_BITS=8 only reaches popcount codes 0..8; the hex codes are used by the word-counter view.
- Combinational paths to io_out are forbidden; all outputs come from flops.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, SHIFT};
  - the 16-entry seg constant table;
  - the SEG_WIDTH=7 constant.
- Sub-module seg7_hex_decoder: combinational, 4-bit in to 7-bit segments, with SEG_INVERT passed through. It is reused by later display blocks.
- Popcount is a local function inside the top module.

Test Plan:
- Reset, then idle 5 cycles: io_out[6:0]=0x3F and io_out[7]=0 throughout.
- Shift 0xB5 (1,0,1,1,0,1,0,1) with strobe 2 high / 2 low, mode=0: after the 8th rising strobe plus 1 clk, seg=0x6D (5) and io_out[7]=1.
- Then shift 0xFF: seg=0x7F (8), io_out[7]=0. Switch mode=1: seg=0x5B (2 words) one cycle later.
- Shift 3 bits, pulse abort (also once coincident with a strobe edge), then shift 0x00: seg=0x3F; frame_cnt increments by exactly 1; the display does not change during the abort.
- Hold strobe high 10 cycles with din=1, then complete the word with seven 0 bits: word=0x80, seg=0x06 (1).
- Send 16 words with mode=1: digit steps 1..9, A..F, then wraps to 0x3F. Assert rst mid-word: all outputs return to reset values on the next edge.
